// File: rtl/led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// led_pwm_ctrl : memory-mapped LED driver with per-bit blink and global PWM.
// Optional PWM dimming is built only when LED_PWM_CTRL_PWM_EN is defined.
// Revision: 1.0
// ============================================================================
module led_pwm_ctrl #(
    parameter int unsigned      N_LED       = 24,
    parameter int unsigned      PWM_BITS    = 8,
    parameter logic [31:0]      BASE_ADDR   = 32'hFFFF_F060,
    parameter logic [N_LED-1:0] RST_PATTERN = 24'h00_FFFF
) (
    input  logic             rst_to_led,
    input  logic             clk_to_led,
    input  logic [31:0]      addr_to_led,
    input  logic             we_to_led,
    input  logic [31:0]      wdata_to_led,
    output logic [31:0]      rdata_from_led,
    output logic [N_LED-1:0] led
);

    localparam logic [31:0] ADDR_DATA   = BASE_ADDR;
    localparam logic [31:0] ADDR_BLINK  = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_DUTY   = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_PERIOD = BASE_ADDR + 32'hC;

    logic [N_LED-1:0] data;
    logic [N_LED-1:0] blink_mask;
    logic [31:0]      period;
    logic [31:0]      prescaler;
    logic             phase;
    logic             pwm_on;
    logic [31:0]      duty_rd;

    logic wr_data;
    logic wr_blink;
    logic wr_duty;
    logic wr_period;

    assign wr_data   = we_to_led && (addr_to_led == ADDR_DATA);
    assign wr_blink  = we_to_led && (addr_to_led == ADDR_BLINK);
    assign wr_duty   = we_to_led && (addr_to_led == ADDR_DUTY);
    assign wr_period = we_to_led && (addr_to_led == ADDR_PERIOD);

    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            data       <= RST_PATTERN;
            blink_mask <= '0;
            period     <= '0;
        end else begin
            if (wr_data)   data       <= wdata_to_led[N_LED-1:0];
            if (wr_blink)  blink_mask <= wdata_to_led[N_LED-1:0];
            if (wr_period) period     <= wdata_to_led;
        end
    end

    // A PERIOD write restarts the blink cycle from the lit phase.
    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            prescaler <= '0;
            phase     <= 1'b1;
        end else if (wr_period || (period == 32'd0)) begin
            prescaler <= '0;
            phase     <= 1'b1;
        end else if (prescaler == period) begin
            prescaler <= '0;
            phase     <= ~phase;
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end

`ifdef LED_PWM_CTRL_PWM_EN
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] pcnt;

    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            duty <= '1;
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PWM_BITS'(1);
            if (wr_duty) duty <= wdata_to_led[PWM_BITS-1:0];
        end
    end

    // All-ones duty means fully on, not 255/256.
    assign pwm_on  = (pcnt < duty) || (&duty);
    assign duty_rd = 32'(duty);
`else
    logic unused_wr_duty;
    assign unused_wr_duty = wr_duty;
    assign pwm_on         = 1'b1;
    assign duty_rd        = '0;
`endif

    always_ff @(posedge clk_to_led or posedge rst_to_led) begin
        if (rst_to_led) begin
            led <= RST_PATTERN;
        end else begin
            led <= data & (~blink_mask | {N_LED{phase}}) & {N_LED{pwm_on}};
        end
    end

    always_comb begin
        rdata_from_led = '0;
        case (addr_to_led)
            ADDR_DATA:   rdata_from_led = 32'(data);
            ADDR_BLINK:  rdata_from_led = 32'(blink_mask);
            ADDR_DUTY:   rdata_from_led = duty_rd;
            ADDR_PERIOD: rdata_from_led = period;
            default:     rdata_from_led = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_led_pwm_ctrl : directed + random stimulus against a timeline-based model.
// Revision: 1.0
// ============================================================================
module tb_led_pwm_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_F060;

    logic        rst;
    logic        clk;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [23:0] led;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: register contents plus elapsed-time counters from which
    // blink phase and PWM position are derived arithmetically.
    logic [23:0] m_data;
    logic [23:0] m_mask;
    logic [7:0]  m_duty;
    logic [31:0] m_period;
    longint      m_t;
    longint      m_cyc;
    logic [23:0] m_exp_led;

    led_pwm_ctrl dut (
        .rst_to_led     (rst),
        .clk_to_led     (clk),
        .addr_to_led    (addr),
        .we_to_led      (we),
        .wdata_to_led   (wdata),
        .rdata_from_led (rdata),
        .led            (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic reset_model();
        m_data    = 24'h00FFFF;
        m_mask    = '0;
        m_duty    = 8'hFF;
        m_period  = '0;
        m_t       = 0;
        m_cyc     = 0;
        m_exp_led = 24'h00FFFF;
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == BASE)          return 32'(m_data);
        if (a == BASE + 32'h4)  return 32'(m_mask);
`ifdef LED_PWM_CTRL_PWM_EN
        if (a == BASE + 32'h8)  return 32'(m_duty);
`endif
        if (a == BASE + 32'hC)  return m_period;
        return 32'h0;
    endfunction

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic ph;
        logic pw;
        longint span;
        span = longint'({32'b0, m_period}) + 1;
        ph = (m_period == 32'd0) ? 1'b1 : (((m_t / span) % 2) == 0);
`ifdef LED_PWM_CTRL_PWM_EN
        pw = ((m_cyc % 256) < longint'({56'b0, m_duty})) || (m_duty == 8'hFF);
`else
        pw = 1'b1;
`endif
        m_exp_led = m_data & (~m_mask | {24{ph}}) & {24{pw}};
        if (w && a == BASE)         m_data   = d[23:0];
        if (w && a == BASE + 32'h4) m_mask   = d[23:0];
        if (w && a == BASE + 32'h8) m_duty   = d[7:0];
        if (w && a == BASE + 32'hC) m_period = d;
        m_t   = (w && a == BASE + 32'hC) ? 0 : m_t + 1;
        m_cyc = m_cyc + 1;
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        chk("led", 32'(led), 32'(m_exp_led));
        chk("rdata", rdata, rd_model(a));
    endtask

    initial begin
        int lit;
        logic [31:0] ra;
        logic [31:0] rd;
        rst = 1'b1; we = 1'b0; addr = BASE; wdata = '0;
        reset_model();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_led", 32'(led), 32'h00FFFF);
        chk("rst_data", rdata, 32'h00FFFF);
        addr = BASE + 32'h8; #1;
`ifdef LED_PWM_CTRL_PWM_EN
        chk("rst_duty", rdata, 32'hFF);
`else
        chk("rst_duty", rdata, 32'h0);
`endif
        addr = BASE + 32'hC; #1;
        chk("rst_period", rdata, 32'h0);
        rst = 1'b0;

        // Write on the very first edge after release must land.
        step(1'b1, BASE, 32'h00A5A5A5);
        step(1'b0, BASE, 32'h0);
        chk("data_led", 32'(led), 32'h00A5A5A5);
        step(1'b1, BASE + 32'h10, 32'hFFFFFFFF);
        step(1'b1, BASE + 32'h1, 32'h0);
        step(1'b0, BASE, 32'h0);
        chk("unmapped_led", 32'(led), 32'h00A5A5A5);
        chk("unmapped_rd", rdata, 32'h00A5A5A5);

        // Blink on the low nibble.
        step(1'b1, BASE, 32'hFFFFFFFF);
        step(1'b1, BASE + 32'h4, 32'h0000000F);
        step(1'b1, BASE + 32'hC, 32'd3);
        for (int i = 0; i < 20; i++) step(1'b0, BASE + 32'hC, 32'h0);

        // Restart the prescaler while it sits at 2.
        step(1'b1, BASE + 32'hC, 32'd4);
        step(1'b0, BASE, 32'h0);
        step(1'b0, BASE, 32'h0);
        step(1'b1, BASE + 32'hC, 32'd5);
        for (int i = 0; i < 16; i++) step(1'b0, BASE + 32'h4, 32'h0);

        step(1'b1, BASE + 32'h4, 32'h0);
`ifdef LED_PWM_CTRL_PWM_EN
        step(1'b1, BASE + 32'h8, 32'd64);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, BASE + 32'h8, 32'h0);
            if (led == 24'hFFFFFF) lit++;
        end
        chk("pwm64_lit", 32'(lit), 32'd64);
        step(1'b1, BASE + 32'h8, 32'd0);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, BASE + 32'h8, 32'h0);
            if (led == 24'hFFFFFF) lit++;
        end
        chk("pwm0_lit", 32'(lit), 32'd0);
        step(1'b1, BASE + 32'h8, 32'd255);
        lit = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, BASE + 32'h8, 32'h0);
            if (led == 24'hFFFFFF) lit++;
        end
        chk("pwm255_lit", 32'(lit), 32'd256);
`else
        step(1'b1, BASE + 32'h8, 32'h40);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, BASE + 32'h8, 32'h0);
            chk("nopwm_led", 32'(led), 32'hFFFFFF);
            chk("nopwm_duty", rdata, 32'h0);
        end
`endif

        // Random bus traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 6))
                0: ra = BASE;
                1: ra = BASE + 32'h4;
                2: ra = BASE + 32'h8;
                3: ra = BASE + 32'hC;
                4: ra = BASE + 32'h10;
                5: ra = BASE + 32'($urandom_range(1, 3));
                default: ra = $urandom;
            endcase
            rd = $urandom;
            if (ra == BASE + 32'hC && $urandom_range(0, 3) != 0) rd = 32'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), ra, rd);
        end

        // Asynchronous reset in the middle of a write.
        step(1'b1, BASE + 32'h4, 32'h00F0F0F0);
        @(posedge clk); #2;
        we = 1'b1; addr = BASE; wdata = 32'h12345678;
        rst = 1'b1; #1;
        chk("arst_led", 32'(led), 32'h00FFFF);
        chk("arst_data", rdata, 32'h00FFFF);
        addr = BASE + 32'h4; #1;
        chk("arst_blink", rdata, 32'h0);
        addr = BASE + 32'h8; #1;
`ifdef LED_PWM_CTRL_PWM_EN
        chk("arst_duty", rdata, 32'hFF);
`else
        chk("arst_duty", rdata, 32'h0);
`endif
        addr = BASE + 32'hC; #1;
        chk("arst_period", rdata, 32'h0);
        @(posedge clk); #1;
        chk("arst_hold_led", 32'(led), 32'h00FFFF);
        rst = 1'b0;
        reset_model();
        step(1'b1, BASE + 32'hC, 32'd2);
        for (int i = 0; i < 12; i++) step(1'b0, BASE, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
